// File: rtl/regbus_master_if.sv
// regbus_master_if: command/response streams and register-bus signals of the regbus initiator
interface regbus_master_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [DATA_W-1:0] cmd_mask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_status;
    logic [CNT_W-1:0]  rsp_attempts;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rsp_ready, read_data,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_status, rsp_attempts,
               wr_en, rd_en, addr, write_data
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rsp_ready, read_data,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_status, rsp_attempts,
               wr_en, rd_en, addr, write_data
    );
endinterface

// File: rtl/regbus_master.sv
// regbus_master: executes WRITE/READ/POLL commands on the register bus, one response per command
module regbus_master #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 16,
    parameter int RD_LAT   = 0,
    parameter int POLL_MAX = 16,
    parameter int CNT_W    = 8
) (
    input logic             clk,
    input logic             rst,
    regbus_master_if.master bus
);
    localparam int LAT_W = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT > 0 ? RD_LAT - 1 : 0);
    localparam logic [CNT_W-1:0] ATT_MAX  = CNT_W'(POLL_MAX);
    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_RSV = 2'b11;
    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_TMO = 2'b01;
    localparam logic [1:0] ST_ILL = 2'b10;

    typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, CHECK, RSP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        status_q, status_d;
    logic [CNT_W-1:0]  att_q, att_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              cmd_ready_q, rsp_valid_q, wr_en_q, rd_en_q;
    logic              match;
    logic              exhausted;
    state_t            after_rd;

    assign match     = ((rdata_q ^ wdata_q) & mask_q) == '0;
    assign exhausted = att_q >= ATT_MAX;
    assign after_rd  = op_q == OP_RD ? RSP : CHECK;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mask_d   = mask_q;
        rdata_d  = rdata_q;
        status_d = status_q;
        att_d    = att_q;
        lat_d    = lat_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    op_d     = bus.cmd_op;
                    addr_d   = bus.cmd_addr;
                    wdata_d  = bus.cmd_wdata;
                    mask_d   = bus.cmd_mask;
                    rdata_d  = '0;
                    att_d    = '0;
                    status_d = bus.cmd_op == OP_RSV ? ST_ILL : ST_OK;
                    state_d  = bus.cmd_op == OP_WR ? WR : bus.cmd_op == OP_RSV ? RSP : RD;
                end
            end
            WR: state_d = RSP;
            RD: begin
                att_d = att_q + 1'b1;
                lat_d = '0;
                if (RD_LAT == 0) begin
                    rdata_d = bus.read_data;
                    state_d = after_rd;
                end else begin
                    state_d = RWAIT;
                end
            end
            RWAIT: begin
                lat_d = lat_q + 1'b1;
                if (lat_q == LAT_LAST) begin
                    rdata_d = bus.read_data;
                    state_d = after_rd;
                end
            end
            CHECK: begin
                state_d  = (match || exhausted) ? RSP : RD;
                status_d = (!match && exhausted) ? ST_TMO : ST_OK;
            end
            RSP: state_d = bus.rsp_ready ? IDLE : RSP;
            default: state_d = IDLE;
        endcase
    end

    // Strobes and handshakes are registered from the next state so every output is a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            rdata_q     <= '0;
            status_q    <= '0;
            att_q       <= '0;
            lat_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
        end else begin
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            rdata_q     <= rdata_d;
            status_q    <= status_d;
            att_q       <= att_d;
            lat_q       <= lat_d;
            cmd_ready_q <= state_d == IDLE;
            rsp_valid_q <= state_d == RSP;
            wr_en_q     <= state_d == WR;
            rd_en_q     <= state_d == RD;
        end
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_rdata    = rdata_q;
    assign bus.rsp_status   = status_q;
    assign bus.rsp_attempts = att_q;
    assign bus.wr_en        = wr_en_q;
    assign bus.rd_en        = rd_en_q;
    assign bus.addr         = addr_q;
    assign bus.write_data   = wdata_q;
endmodule

// File: tb/tb_regbus_master.sv
// tb_regbus_master: directed vectors on a RD_LAT=0 instance plus latency/timeout/reset sequences on a RD_LAT=2, POLL_MAX=4 instance
module tb_regbus_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regbus_master_if #(.ADDR_W(14), .DATA_W(16), .CNT_W(8)) b0();
    regbus_master_if #(.ADDR_W(14), .DATA_W(16), .CNT_W(8)) b1();

    regbus_master #(.ADDR_W(14), .DATA_W(16), .RD_LAT(0), .POLL_MAX(16), .CNT_W(8))
        u0 (.clk(clk), .rst(rst), .bus(b0));
    regbus_master #(.ADDR_W(14), .DATA_W(16), .RD_LAT(2), .POLL_MAX(4), .CNT_W(8))
        u1 (.clk(clk), .rst(rst), .bus(b1));

    typedef struct {
        logic [1:0]  op;
        logic [13:0] addr;
        logic [15:0] wdata;
        logic [15:0] mask;
        logic [63:0] rs;
        logic [15:0] e_rdata;
        logic [1:0]  e_st;
        logic [7:0]  e_att;
        int          e_rd;
        int          e_wr;
        int          e_lat;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // u0 responder: the k-th read of a command returns slot k of cur_rs (last slot repeats)
    logic [63:0] cur_rs = '0;
    int rd_idx0 = 0;
    int base0 = 0;
    always @(posedge clk) if (b0.rd_en) rd_idx0 <= rd_idx0 + 1;
    always_comb begin : rdsel
        int k;
        k = rd_idx0 - base0;
        if (k > 3) k = 3;
        if (k < 0) k = 0;
        b0.read_data = cur_rs[k*16 +: 16];
    end

    // u1 responder: valid data only two cycles after rd_en, 0xDEAD otherwise
    logic [15:0] rval1 = '0;
    logic d1 = 1'b0, d2 = 1'b0;
    always @(posedge clk) begin
        d1 <= b1.rd_en;
        d2 <= d1;
    end
    assign b1.read_data = d2 ? rval1 : 16'hDEAD;

    int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0, ovl = 0, bad0 = 0;
    logic [13:0] exp_addr0 = '0;
    logic [15:0] exp_wd0 = '0;
    always @(negedge clk) begin
        if (b0.wr_en) wr0++;
        if (b0.rd_en) rd0++;
        if (b1.wr_en) wr1++;
        if (b1.rd_en) rd1++;
        if ((b0.wr_en && b0.rd_en) || (b1.wr_en && b1.rd_en)) ovl++;
        if ((b0.wr_en || b0.rd_en) && b0.addr !== exp_addr0) bad0++;
        if (b0.wr_en && b0.write_data !== exp_wd0) bad0++;
    end

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
        end
    endtask

    function automatic logic rv(input int w);
        return w == 0 ? b0.rsp_valid : b1.rsp_valid;
    endfunction

    task automatic send(input int w, input logic [1:0] op, input logic [13:0] a,
                        input logic [15:0] d, input logic [15:0] m);
        int n = 0;
        while (!(w == 0 ? b0.cmd_ready : b1.cmd_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (w == 0) begin
            b0.cmd_valid = 1'b1; b0.cmd_op = op; b0.cmd_addr = a; b0.cmd_wdata = d; b0.cmd_mask = m;
        end else begin
            b1.cmd_valid = 1'b1; b1.cmd_op = op; b1.cmd_addr = a; b1.cmd_wdata = d; b1.cmd_mask = m;
        end
        @(negedge clk);
        if (w == 0) b0.cmd_valid = 1'b0;
        else        b1.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int w, output int lat);
        lat = 1;
        while (!rv(w) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("rsp_valid arrives", rv(w), 1'b1);
    endtask

    vec_t v[9];

    function automatic vec_t mk(input logic [1:0] op, input logic [13:0] a, input logic [15:0] d,
                                input logic [15:0] m, input logic [15:0] r0, input logic [15:0] r1,
                                input logic [15:0] r2, input logic [15:0] r3, input logic [15:0] er,
                                input logic [1:0] es, input logic [7:0] ea, input int erd,
                                input int ewr, input int elat);
        vec_t t;
        t.op = op; t.addr = a; t.wdata = d; t.mask = m; t.rs = {r3, r2, r1, r0};
        t.e_rdata = er; t.e_st = es; t.e_att = ea; t.e_rd = erd; t.e_wr = ewr; t.e_lat = elat;
        return t;
    endfunction

    initial begin
        #100000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int lat, s_rd, s_wr, bad;
        logic [25:0] snap;
        b0.cmd_valid = 0; b0.cmd_op = 0; b0.cmd_addr = 0; b0.cmd_wdata = 0; b0.cmd_mask = 0; b0.rsp_ready = 1;
        b1.cmd_valid = 0; b1.cmd_op = 0; b1.cmd_addr = 0; b1.cmd_wdata = 0; b1.cmd_mask = 0; b1.rsp_ready = 1;

        v[0] = mk(2'b00, 14'h201,  16'h0020, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000, 2'b00, 8'd0, 0, 1, 2);
        v[1] = mk(2'b01, 14'h209,  16'h0000, 16'h0000, 16'h0010, 16'h0, 16'h0, 16'h0, 16'h0010, 2'b00, 8'd1, 1, 0, 2);
        v[2] = mk(2'b10, 14'h20a,  16'h0005, 16'h00FF, 16'h1100, 16'h0003, 16'hAB05, 16'hAB05, 16'hAB05, 2'b00, 8'd3, 3, 0, 7);
        v[3] = mk(2'b10, 14'h010,  16'h5555, 16'h0000, 16'h1234, 16'h0, 16'h0, 16'h0, 16'h1234, 2'b00, 8'd1, 1, 0, 3);
        v[4] = mk(2'b11, 14'h020,  16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000, 2'b10, 8'd0, 0, 0, 1);
        v[5] = mk(2'b01, 14'h3FFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'hFFFF, 2'b00, 8'd1, 1, 0, 2);
        v[6] = mk(2'b10, 14'h100,  16'h8000, 16'h8000, 16'h7FFF, 16'h8001, 16'h8001, 16'h8001, 16'h8001, 2'b00, 8'd2, 2, 0, 5);
        v[7] = mk(2'b10, 14'h101,  16'hBEEF, 16'hFFFF, 16'hBEEF, 16'h0, 16'h0, 16'h0, 16'hBEEF, 2'b00, 8'd1, 1, 0, 3);
        v[8] = mk(2'b10, 14'h102,  16'h0001, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000, 2'b01, 8'd16, 16, 0, 33);

        // reset state and first edge after release
        repeat (2) @(negedge clk);
        chk("reset outputs u0", {b0.cmd_ready, b0.rsp_valid, b0.wr_en, b0.rd_en, b0.addr, b0.write_data,
                                 b0.rsp_rdata, b0.rsp_status, b0.rsp_attempts}, '0);
        rst = 1'b0;
        #1 chk("cmd_ready low before first edge", b0.cmd_ready, 1'b0);
        @(negedge clk);
        chk("cmd_ready after first edge", {b0.cmd_ready, b1.cmd_ready}, 2'b11);

        foreach (v[i]) begin
            cur_rs = v[i].rs; base0 = rd_idx0; exp_addr0 = v[i].addr; exp_wd0 = v[i].wdata;
            s_rd = rd0; s_wr = wr0;
            send(0, v[i].op, v[i].addr, v[i].wdata, v[i].mask);
            wait_rsp(0, lat);
            chk($sformatf("v%0d rdata", i), b0.rsp_rdata, v[i].e_rdata);
            chk($sformatf("v%0d status", i), b0.rsp_status, v[i].e_st);
            chk($sformatf("v%0d attempts", i), b0.rsp_attempts, v[i].e_att);
            chk($sformatf("v%0d rd pulses", i), rd0 - s_rd, v[i].e_rd);
            chk($sformatf("v%0d wr pulses", i), wr0 - s_wr, v[i].e_wr);
            chk($sformatf("v%0d latency", i), lat, v[i].e_lat);
            @(negedge clk);
            chk($sformatf("v%0d rsp dropped", i), {b0.rsp_valid, b0.cmd_ready}, 2'b01);
        end
        chk("u0 bus addr/data at strobes", bad0, 0);

        // RD_LAT=2: sample taken late, 0xDEAD in early cycles ignored
        rval1 = 16'h0010; s_rd = rd1;
        send(1, 2'b01, 14'h209, 16'h0, 16'h0);
        wait_rsp(1, lat);
        chk("lat2 read rdata", b1.rsp_rdata, 16'h0010);
        chk("lat2 read latency", lat, 4);
        chk("lat2 read rd pulses", rd1 - s_rd, 1);
        @(negedge clk);

        // POLL_MAX=4 timeout
        rval1 = 16'h0000; s_rd = rd1;
        send(1, 2'b10, 14'h0AA, 16'h0001, 16'h0001);
        wait_rsp(1, lat);
        chk("timeout status", b1.rsp_status, 2'b01);
        chk("timeout attempts", b1.rsp_attempts, 8'd4);
        chk("timeout rd pulses", rd1 - s_rd, 4);
        chk("timeout latency", lat, 17);
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("no 5th read", rd1 - s_rd, 4);

        // back-to-back with response held off 5 cycles
        b0.rsp_ready = 1'b0;
        cur_rs = {48'h0, 16'h00A5}; base0 = rd_idx0; exp_addr0 = 14'h055;
        send(0, 2'b01, 14'h055, 16'h0, 16'h0);
        wait_rsp(0, lat);
        snap = {b0.rsp_rdata, b0.rsp_status, b0.rsp_attempts};
        chk("held rdata", b0.rsp_rdata, 16'h00A5);
        b0.cmd_valid = 1'b1; b0.cmd_op = 2'b11; b0.cmd_addr = 14'h077;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if ({b0.rsp_rdata, b0.rsp_status, b0.rsp_attempts} !== snap || !b0.rsp_valid || b0.cmd_ready) bad++;
        end
        chk("rsp stable while held", bad, 0);
        s_rd = rd0; s_wr = wr0;
        b0.rsp_ready = 1'b1;
        @(negedge clk);
        chk("after handshake idle, not yet accepted", {b0.rsp_valid, b0.cmd_ready}, 2'b01);
        @(negedge clk);
        b0.cmd_valid = 1'b0;
        chk("illegal op response", {b0.rsp_valid, b0.cmd_ready, b0.rsp_status, b0.rsp_attempts, b0.rsp_rdata},
            {1'b1, 1'b0, 2'b10, 8'd0, 16'h0});
        @(negedge clk);
        chk("illegal op no strobes", (rd0 - s_rd) + (wr0 - s_wr), 0);

        // asynchronous reset during RWAIT
        rval1 = 16'h5555;
        send(1, 2'b01, 14'h123, 16'h0, 16'h0);
        chk("abort rd_en seen", b1.rd_en, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("abort outputs zero", {b1.cmd_ready, b1.rsp_valid, b1.wr_en, b1.rd_en, b1.addr, b1.write_data,
                                      b1.rsp_rdata, b1.rsp_status, b1.rsp_attempts}, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready after abort release", {b1.cmd_ready, b1.rsp_valid}, 2'b10);
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (b1.rsp_valid || b1.rd_en) bad++;
        end
        chk("no response after abort", bad, 0);

        chk("strobe overlap", ovl, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
